// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: parity mode, bit order and tx state encoding,
// plus the parity helper used when a byte is moved into the shifter.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_e;

  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } bit_order_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Unused upper bits are zero and do not disturb the XOR.
  function automatic logic parity_bit(input logic [8:0] d, input parity_e mode);
    return (^d) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: one-entry holding register feeding a shifter,
// each serial bit held for OVERSAMPLE ticks of an external sample_trigger.
//
// state     | meaning
// ST_IDLE   | line idle high, waiting for a tick with a byte pending
// ST_START  | start bit (0)
// ST_DATA   | data bits in BIT_ORDER
// ST_PARITY | parity bit (never entered with PARITY_NONE)
// ST_STOP   | STOP_BITS stop bits (1)
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int         DATA_BITS  = 8,
  parameter int         OVERSAMPLE = 16,
  parameter parity_e    PARITY     = PARITY_NONE,
  parameter int         STOP_BITS  = 1,
  parameter bit_order_e BIT_ORDER  = MSB_FIRST
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_trigger,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 start,
  output logic                 serial_data,
  output logic                 ready,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OVERSAMPLE - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 2 || OVERSAMPLE > 64) begin : g_bad_oversample
    $error("uart_tx_param: OVERSAMPLE must be 2..64");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_param: illegal PARITY mode");
  end

  tx_state_e            r_state;
  logic                 r_init;
  logic                 r_hold_full;
  logic [DATA_BITS-1:0] r_hold;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic [CNT_W-1:0]     r_sample_cnt;
  logic [3:0]           r_bit_cnt;
  logic                 r_serial;

  logic                 w_accept;
  logic                 w_pend;
  logic [DATA_BITS-1:0] w_pend_data;
  logic                 w_last_stop;
  logic                 w_launch;
  logic                 w_next_bit;
  logic [DATA_BITS-1:0] w_shifted;

  // ready stays low until the first edge after reset is released.
  assign ready       = r_init & ~r_hold_full;
  assign busy        = (r_state != ST_IDLE);
  assign serial_data = r_serial;

  // A start accepted on the launch edge passes straight through to the shifter.
  assign w_accept    = start & ready;
  assign w_pend      = r_hold_full | w_accept;
  assign w_pend_data = r_hold_full ? r_hold : data;
  assign w_last_stop = (r_state == ST_STOP) && (r_sample_cnt == '0) && (r_bit_cnt == 4'd0);
  assign w_launch    = sample_trigger && w_pend && ((r_state == ST_IDLE) || w_last_stop);

  assign w_next_bit  = (BIT_ORDER == MSB_FIRST) ? r_shift[DATA_BITS-1] : r_shift[0];
  assign w_shifted   = (BIT_ORDER == MSB_FIRST) ? {r_shift[DATA_BITS-2:0], 1'b0}
                                                : {1'b0, r_shift[DATA_BITS-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_init       <= 1'b0;
      r_hold_full  <= 1'b0;
      r_hold       <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_sample_cnt <= '0;
      r_bit_cnt    <= 4'd0;
      r_serial     <= 1'b1;
    end else begin
      r_init <= 1'b1;
      if (w_accept) r_hold <= data;
      if (w_launch) r_hold_full <= 1'b0;
      else if (w_accept) r_hold_full <= 1'b1;

      if (w_launch) begin
        r_state      <= ST_START;
        r_serial     <= 1'b0;
        r_shift      <= w_pend_data;
        r_parity     <= parity_bit(9'(w_pend_data), PARITY);
        r_sample_cnt <= CNT_LOAD;
      end else if (sample_trigger && r_state != ST_IDLE) begin
        r_sample_cnt <= (r_sample_cnt == '0) ? CNT_LOAD : r_sample_cnt - 1'b1;
        if (r_sample_cnt == '0) begin
          case (r_state)
            ST_START: begin
              r_state   <= ST_DATA;
              r_serial  <= w_next_bit;
              r_shift   <= w_shifted;
              r_bit_cnt <= 4'(DATA_BITS - 1);
            end
            ST_DATA: begin
              if (r_bit_cnt != 4'd0) begin
                r_serial  <= w_next_bit;
                r_shift   <= w_shifted;
                r_bit_cnt <= r_bit_cnt - 4'd1;
              end else if (PARITY == PARITY_NONE) begin
                r_state   <= ST_STOP;
                r_serial  <= 1'b1;
                r_bit_cnt <= 4'(STOP_BITS - 1);
              end else begin
                r_state  <= ST_PARITY;
                r_serial <= r_parity;
              end
            end
            ST_PARITY: begin
              r_state   <= ST_STOP;
              r_serial  <= 1'b1;
              r_bit_cnt <= 4'(STOP_BITS - 1);
            end
            ST_STOP: begin
              if (r_bit_cnt != 4'd0) begin
                r_bit_cnt <= r_bit_cnt - 4'd1;
              end else begin
                r_state      <= ST_IDLE;
                r_serial     <= 1'b1;
                r_sample_cnt <= '0;
              end
            end
            default: begin
              r_state  <= ST_IDLE;
              r_serial <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations share one tick source; a frame-level
// model (bit list + tick count) is compared against every DUT output each cycle.
module tb_uart_tx_param;
  import uart_pkg::*;

  localparam int C_DB   [3] = '{8, 8, 5};
  localparam int C_OS   [3] = '{16, 16, 4};
  localparam int C_PAR  [3] = '{0, 1, 2};
  localparam int C_STOP [3] = '{1, 2, 1};
  localparam int C_LSB  [3] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       rst;
  logic       r_trig = 1'b0;
  int         pg_cnt = 0;
  logic [2:0] r_start;
  logic [8:0] r_data [3];
  logic [2:0] w_ser, w_rdy, w_busy;
  int         total = 0;
  int         bad = 0;

  bit          m_init [3];
  bit          m_hfull[3];
  logic [8:0]  m_hval [3];
  bit          m_act  [3];
  logic [15:0] m_bits [3];
  int          m_len  [3];
  int          m_pos  [3];
  int          m_tick [3];

  always #5 clk = ~clk;

  // pulse generator, INTERVAL = 10
  always @(posedge clk) begin
    pg_cnt <= (pg_cnt == 9) ? 0 : pg_cnt + 1;
    r_trig <= (pg_cnt == 9);
  end

  uart_tx_param u_dut0 (
    .clk(clk), .rst(rst), .sample_trigger(r_trig), .data(r_data[0][7:0]), .start(r_start[0]),
    .serial_data(w_ser[0]), .ready(w_rdy[0]), .busy(w_busy[0]));

  uart_tx_param #(.PARITY(PARITY_EVEN), .STOP_BITS(2), .BIT_ORDER(LSB_FIRST)) u_dut1 (
    .clk(clk), .rst(rst), .sample_trigger(r_trig), .data(r_data[1][7:0]), .start(r_start[1]),
    .serial_data(w_ser[1]), .ready(w_rdy[1]), .busy(w_busy[1]));

  uart_tx_param #(.DATA_BITS(5), .OVERSAMPLE(4), .PARITY(PARITY_ODD)) u_dut2 (
    .clk(clk), .rst(rst), .sample_trigger(r_trig), .data(r_data[2][4:0]), .start(r_start[2]),
    .serial_data(w_ser[2]), .ready(w_rdy[2]), .busy(w_busy[2]));

  // Whole frame as a bit list, first bit on the line at index 0.
  function automatic void make_frame(input int i, input logic [8:0] v,
                                     output logic [15:0] bits, output int len);
    int ones = 0;
    logic b;
    bits = '1;
    bits[0] = 1'b0;
    len = 1;
    for (int k = 0; k < C_DB[i]; k++) begin
      b = (C_LSB[i] != 0) ? v[k] : v[C_DB[i]-1-k];
      bits[len] = b;
      ones += int'(b);
      len++;
    end
    if (C_PAR[i] != 0) begin
      bits[len] = ((ones % 2) == 1) ^ (C_PAR[i] == 2);
      len++;
    end
    len += C_STOP[i];
  endfunction

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_init[i] = 0; m_hfull[i] = 0; m_act[i] = 0; m_pos[i] = 0; m_tick[i] = 0;
      end else begin
        if (r_start[i] && m_init[i] && !m_hfull[i]) begin
          m_hfull[i] = 1;
          m_hval[i]  = r_data[i];
        end
        if (r_trig) begin
          if (m_act[i]) begin
            m_tick[i]++;
            if (m_tick[i] == C_OS[i]) begin
              m_tick[i] = 0;
              m_pos[i]++;
              if (m_pos[i] == m_len[i]) m_act[i] = 0;
            end
          end
          if (!m_act[i] && m_hfull[i]) begin
            make_frame(i, m_hval[i], m_bits[i], m_len[i]);
            m_act[i] = 1; m_pos[i] = 0; m_tick[i] = 0; m_hfull[i] = 0;
          end
        end
        m_init[i] = 1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pin_model(input int i, input logic [8:0] v, input int nexp,
                           input logic [31:0] lit, input string name);
    logic [15:0] b;
    int n;
    logic [31:0] seq = 0;
    make_frame(i, v, b, n);
    chk({name, "_len"}, n, nexp);
    for (int k = 0; k < n; k++) seq = {seq[30:0], b[k]};
    chk(name, int'(seq), int'(lit));
  endtask

  task automatic send(input int i, input logic [8:0] v);
    int w = 0;
    @(posedge clk); #2;
    while (!w_rdy[i] && w < 5000) begin @(posedge clk); #2; w++; end
    chk($sformatf("send_ready%0d", i), int'(w_rdy[i]), 1);
    r_data[i]  = v;
    r_start[i] = 1'b1;
    @(posedge clk); #2;
    r_start[i] = 1'b0;
  endtask

  // Samples the line mid-bit; the literal holds the first bit in its MSB.
  task automatic sample_stream(input int i, input int nbits, input logic [31:0] lit,
                               input string name);
    int bit_clk = C_OS[i] * 10;
    int waited = 0;
    logic [31:0] got = 0;
    while (w_ser[i] !== 1'b0 && waited < 400) begin @(posedge clk); #1; waited++; end
    chk({name, "_start_seen"}, int'(waited < 400), 1);
    if (waited >= 400) return;
    repeat (bit_clk / 2) @(posedge clk);
    #1 got = {got[30:0], w_ser[i]};
    for (int k = 1; k < nbits; k++) begin
      repeat (bit_clk) @(posedge clk);
      #1 got = {got[30:0], w_ser[i]};
    end
    chk(name, int'(got), int'(lit));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rst = 1'b1;
    r_start = 3'b111;
    for (int i = 0; i < 3; i++) r_data[i] = 9'h1FF;

    fork
      forever begin
        @(posedge clk or posedge rst);
        model_step();
      end
      forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("serial%0d", i), int'(w_ser[i]),
              m_act[i] ? int'(m_bits[i][m_pos[i]]) : 1);
          chk($sformatf("ready%0d", i), int'(w_rdy[i]), int'(m_init[i] && !m_hfull[i]));
          chk($sformatf("busy%0d", i), int'(w_busy[i]), int'(m_act[i]));
        end
      end
    join_none

    pin_model(0, 9'hD5, 10, 32'b0110101011, "model_d5");
    pin_model(1, 9'hA5, 12, 32'b010100101011, "model_a5");
    pin_model(2, 9'h16, 8, 32'b01011001, "model_10110");

    // long reset with start held high
    repeat (3000) @(posedge clk);
    #2 r_start = 3'b000;
    @(posedge clk); #2 rst = 1'b0;
    #1 chk("ready_before_first_edge", int'(w_rdy), 0);
    @(posedge clk); #1 chk("ready_after_first_edge", int'(w_rdy), 7);

    // one frame per configuration, then a long idle
    fork
      send(0, 9'hD5);
      sample_stream(0, 10, 32'b0110101011, "frame_default");
      send(1, 9'hA5);
      sample_stream(1, 12, 32'b010100101011, "frame_lsb_even_2stop");
      send(2, 9'h16);
      sample_stream(2, 8, 32'b01011001, "frame_5bit_odd");
    join
    repeat (3000) @(posedge clk);
    #1 chk("idle_ready", int'(w_rdy[0]), 1);
    chk("idle_busy", int'(w_busy[0]), 0);
    chk("idle_line", int'(w_ser[0]), 1);

    // back-to-back, plus a start ignored while the holding register is full
    fork
      begin
        send(0, 9'hD5);
        w = 0;
        while (!w_busy[0] && w < 400) begin @(posedge clk); #2; w++; end
        send(0, 9'hBD);
        chk("hold_full_ready", int'(w_rdy[0]), 0);
        r_data[0] = 9'hFF;
        r_start[0] = 1'b1;
        repeat (5) @(posedge clk);
        #2 r_start[0] = 1'b0;
      end
      sample_stream(0, 20, 32'b0110101011_0101111011, "back_to_back");
    join
    repeat (400) @(posedge clk);
    #1 chk("ignored_start_no_frame", int'(w_busy[0]), 0);

    // start on the very edge of the final stop-bit tick
    send(2, 9'h13);
    w = 0;
    while (!(m_act[2] && m_pos[2] == m_len[2] - 1 && m_tick[2] == C_OS[2] - 1 && r_trig)
           && w < 1000) begin
      @(posedge clk); #2; w++;
    end
    chk("collide_reached", int'(w < 1000), 1);
    r_data[2] = 9'h0A;
    r_start[2] = 1'b1;
    @(posedge clk); #1;
    chk("collide_start_bit", int'(w_ser[2]), 0);
    chk("collide_busy", int'(w_busy[2]), 1);
    chk("collide_ready", int'(w_rdy[2]), 1);
    #1 r_start[2] = 1'b0;
    repeat (400) @(posedge clk);

    // reset in the middle of data bit 4 of an all-zero byte
    send(0, 9'h00);
    w = 0;
    while (!w_busy[0] && w < 400) begin @(posedge clk); #2; w++; end
    repeat (720) @(posedge clk);
    #2 chk("line_low_before_abort", int'(w_ser[0]), 0);
    rst = 1'b1;
    #1 chk("abort_line_high", int'(w_ser[0]), 1);
    chk("abort_busy", int'(w_busy[0]), 0);
    chk("abort_ready", int'(w_rdy[0]), 0);
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("abort_ready_before_edge", int'(w_rdy[0]), 0);
    @(posedge clk); #1 chk("abort_ready_after_edge", int'(w_rdy[0]), 1);

    // random traffic, starts frequently issued while not ready
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #2;
      for (int i = 0; i < 3; i++) begin
        r_start[i] = ($urandom_range(0, 7) == 0);
        r_data[i]  = 9'($urandom);
      end
    end
    @(posedge clk); #2 r_start = 3'b000;
    repeat (5000) @(posedge clk);
    #1 chk("drain_busy", int'(w_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
